pio_in_debounced: RTL



---
 rtl/pio_in_pkg.sv | 28 ++
 rtl/pio_debounce_bit.sv | 50 +++++
 rtl/pio_in_debounced.sv | 117 +++++++++++
 3 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced input PIO: Avalon register offsets
// (standard Altera PIO layout) and the edge-capture type encodings.
package pio_in_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Edge event selection for one bit, given its current and previous debounced level.
  function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (edge_type)
      EDGE_RISING:  hit = cur & ~prev;
      EDGE_FALLING: hit = ~cur & prev;
      default:      hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: multi-stage synchroniser followed by a persistence counter.
// A new level is accepted into 'stable' only after it has differed from the
// current stable level for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain; the oldest stage feeds the debouncer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Persistence counter: restarts whenever the synchronised level matches stable again.
  // NOTE: reset is asynchronous so a mid-count reset discards the count immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pio_in_debounced.sv
// Parametrised Avalon-MM input PIO with per-bit debouncing, edge capture and
// a maskable level interrupt. Register offsets follow the standard PIO map so
// existing HAL drivers keep working.
module pio_in_debounced
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;

  // Bits of writedata above WIDTH carry no meaning for this block.
  assign unused_wdata = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[gi]),
        .stable (stable[gi])
      );
    end
  endgenerate

  // One-cycle delayed copy of the debounced levels for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // Per-bit edge events and write-1-to-clear mask.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    edge_event = '0;
    edge_clr   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_event[i] = edge_hit(EDGE_TYPE, stable[i], stable_d[i]);
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
  end

  // Edge-capture register: a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~edge_clr) | edge_event;
    end
  end

  // Interrupt mask register; only the low WIDTH bits are stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux; DATA and DIRECTION ignore writes, unused upper bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  // Interrupt is a function of registers only, never of the bus inputs.
  assign irq = |(edgecapture & irqmask);

endmodule
